// File: rtl/sevenseg_mux_if.sv
// Seven-segment scan bundle: digit data and scan strobe toward the driver,
// anode/cathode drive back from it (master = stimulus side, slave = driver).
interface sevenseg_mux_if;
   logic       scan_en;
   logic [3:0] d3;
   logic [3:0] d2;
   logic [3:0] d1;
   logic [3:0] d0;
   logic [7:0] an;
   logic [6:0] seg;

   modport master (
      output scan_en, d3, d2, d1, d0,
      input  an, seg
   );

   modport slave (
      input  scan_en, d3, d2, d1, d0,
      output an, seg
   );
endinterface

// File: rtl/sevenseg_mux.sv
// Four-digit multiplexed seven-segment driver with active-low an/seg outputs.
// Ports: clk, rst (sync, active-high), bus (slave: scan_en, d3..d0 -> an, seg).
module sevenseg_mux (
   input  logic          clk,
   input  logic          rst,
   sevenseg_mux_if.slave bus
);

   logic [1:0] idx_q, idx_d;
   logic [7:0] an_q, an_d;
   logic [6:0] seg_q, seg_d;
   logic [3:0] sel;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h7F; // F blanks the digit
      endcase
      return s;
   endfunction

   always_comb begin
      sel = bus.d0;
      case (idx_q)
         2'd0: sel = bus.d0;
         2'd1: sel = bus.d1;
         2'd2: sel = bus.d2;
         default: sel = bus.d3;
      endcase
      idx_d = bus.scan_en ? idx_q + 2'd1 : idx_q;
      // upper four anodes are unused and stay off
      an_d  = {4'hF, ~(4'b0001 << idx_q)};
      seg_d = decode(sel);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= 2'd0;
         an_q  <= 8'hFF;
         seg_q <= 7'h7F;
      end else begin
         idx_q <= idx_d;
         an_q  <= an_d;
         seg_q <= seg_d;
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;

endmodule

// File: tb/tb_sevenseg_mux.sv
// Directed bench for sevenseg_mux: reset, scan order, countdown, pause,
// full decode sweep on digit 0 and mid-scan reset.
module tb_sevenseg_mux;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;
   logic [1:0] m_idx = 2'd0;

   sevenseg_mux_if bus ();

   sevenseg_mux u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] dec(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   task automatic check8(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: predict outputs from pre-edge state/inputs, then compare.
   task automatic tick(input string tag);
      logic [7:0] e_an;
      logic [6:0] e_seg;
      logic [3:0] v;
      if (rst) begin
         e_an  = 8'hFF;
         e_seg = 7'h7F;
      end else begin
         case (m_idx)
            2'd0: begin e_an = 8'hFE; v = bus.d0; end
            2'd1: begin e_an = 8'hFD; v = bus.d1; end
            2'd2: begin e_an = 8'hFB; v = bus.d2; end
            default: begin e_an = 8'hF7; v = bus.d3; end
         endcase
         e_seg = dec(v);
      end
      if (rst) m_idx = 2'd0;
      else if (bus.scan_en) m_idx = m_idx + 2'd1;
      @(posedge clk);
      #1;
      check8({tag, ".an"}, bus.an, e_an);
      check8({tag, ".seg"}, {1'b0, bus.seg}, {1'b0, e_seg});
   endtask

   initial begin
      @(negedge clk);
      rst = 1'b1;
      bus.scan_en = 1'b1;
      bus.d3 = 4'hF;
      bus.d2 = 4'hF;
      bus.d1 = 4'h1;
      bus.d0 = 4'h0;

      for (int i = 0; i < 5; i++) tick("reset");

      rst = 1'b0;
      tick("scan0");
      check8("first_an", bus.an, 8'hFE);
      check8("first_seg", {1'b0, bus.seg}, 8'h40);
      tick("scan1");
      check8("scan1_seg", {1'b0, bus.seg}, 8'h79);
      for (int i = 0; i < 6; i++) tick("scan");

      for (int v = 10; v >= 0; v--) begin
         bus.d1 = 4'(v / 10);
         bus.d0 = 4'(v % 10);
         for (int i = 0; i < 8; i++) tick("count");
      end

      for (int i = 0; i < 4 && m_idx != 2'd2; i++) tick("seek2");
      bus.scan_en = 1'b0;
      for (int i = 0; i < 6; i++) tick("pause");
      check8("pause_an", bus.an, 8'hFB);
      bus.scan_en = 1'b1;
      tick("resume_hold");
      tick("resume");
      check8("resume_an", bus.an, 8'hF7);

      rst = 1'b1;
      tick("rst_sweep");
      rst = 1'b0;
      bus.scan_en = 1'b0;
      for (int v = 0; v < 16; v++) begin
         bus.d0 = 4'(v);
         tick("sweep");
      end
      bus.d0 = 4'hA;
      tick("sweepA");
      check8("sweepA_seg", {1'b0, bus.seg}, 8'h08);

      bus.scan_en = 1'b1;
      bus.d0 = 4'h7;
      for (int i = 0; i < 4 && m_idx != 2'd3; i++) tick("seek3");
      tick("at3");
      check8("at3_an", bus.an, 8'hF7);
      rst = 1'b1;
      tick("midrst");
      check8("midrst_an", bus.an, 8'hFF);
      check8("midrst_seg", {1'b0, bus.seg}, 8'h7F);
      rst = 1'b0;
      tick("post");
      check8("post_an", bus.an, 8'hFE);
      check8("post_seg", {1'b0, bus.seg}, 8'h78);
      tick("post2");
      check8("post2_an", bus.an, 8'hFD);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sevenseg_mux.md
SEVENSEG_MUX -- requirements
Module: sevenseg_mux

Interface
REQ-001 Reset rst is synchronous and active-high; clock is clk.
REQ-002 clk  input  1  system clock, all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 scan_en  input  1  digit-advance strobe; one digit step per clk cycle in which it is high.
REQ-005 d3  input  4  value for digit 3 (leftmost).
REQ-006 d2  input  4  value for digit 2.
REQ-007 d1  input  4  value for digit 1.
REQ-008 d0  input  4  value for digit 0 (rightmost).
REQ-009 an  output  8  anode enables, active-low, an[i] selects digit i.
REQ-010 seg  output  7  cathodes, active-low, bit order seg[6:0] = {g,f,e,d,c,b,a}.

Function
REQ-011 The block SHALL hold a 2-bit scan index idx selecting one of digits 0..3.
REQ-012 On a non-reset edge with scan_en=1, idx SHALL advance idx+1 mod 4 (3 -> 0 wrap); with scan_en=0, idx SHALL hold.
REQ-013 an and seg SHALL be registered; on every non-reset edge they SHALL load from the pre-edge idx and pre-edge d inputs (one-cycle latency from idx/data to outputs).
REQ-014 The loaded an SHALL be all ones except an[idx]=0; an[7:4] SHALL always be 1.
REQ-015 The loaded seg SHALL be the decode of the d input selected by idx (idx=0 -> d0 ... idx=3 -> d3).
REQ-016 Decode (hex seg value): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-017 Decode: A=08, b=03, C=46, d=21, E=06.
REQ-018 Value 4'hF SHALL decode to blank, seg=7F (all segments off); used for leading-digit suppression.
REQ-019 Changes on d inputs SHALL appear on seg no later than the second edge after the change while the digit is selected; no input latching beyond REQ-013.
REQ-020 Exactly one of an[3:0] SHALL be low at any time outside reset, no glitch states between digits.
REQ-021 The block SHALL contain no internal prescaler; refresh rate is set solely by scan_en.

Reset
REQ-022 With rst=1 at an edge: idx<=0, an<=8'hFF, seg<=7'h7F, regardless of scan_en or d inputs.
REQ-023 rst SHALL take priority over scan_en in the same cycle.
REQ-024 On the first edge after rst falls, outputs SHALL show digit 0 (an=8'hFE, seg=decode(d0)); idx advances on that edge if scan_en=1.
REQ-025 Reset asserted mid-scan SHALL return to idx=0 and blank outputs on that edge with no residual state.

Verification
REQ-026 rst=1 for 5 cycles, d3..d0=F,F,1,0 -> an=FF, seg=7F every cycle during reset.
REQ-027 Release rst, scan_en held 1, d3..d0=F,F,1,0 -> an sequence FE,FD,FB,F7,FE...; seg sequence 40,79,7F,7F,40...
REQ-028 Countdown: step d1:d0 from 1:0 to 0:0 every 8 cycles (10,09,...,01,00) -> seg for digit 0 tracks 0,9,8,...,1,0 decode values; digit 1 shows 79 then 40.
REQ-029 scan_en=0 for 6 cycles after idx=2 -> an holds FB, seg holds decode(d2); resumes to F7 when scan_en returns to 1.
REQ-030 Sweep each digit value 0..F on d0 with idx fixed at 0 -> seg matches REQ-016..REQ-018 table exactly.
REQ-031 Assert rst for one cycle while an=F7 -> next edge an=FF, seg=7F; after release, first outputs an=FE, seg=decode(d0).
